gray_step_monitor: RTL and testbench
====================================

Name: gray_step_monitor

Overview:
Downstream consumer of the 3-bit Gray-code counter. It synchronises the Gray word into the local clock domain and converts it to binary. It also checks that every change is a legal single forward step, and counts wraps and errors. Its outputs drive the status/debug logic that needs a binary count and a health flag for the counter.

Parameters:
WIDTH, 3, Gray/binary word width
SYNC_STAGES, 2, synchroniser flop depth on GrayIn (min 2)
CNT_W, 8, width of WrapCnt and ErrCnt (saturating)

Ports:
Clk  in  1  single clock, all flops on rising edge
Reset  in  1  asynchronous, active-high; clears every flop immediately
GrayIn  in  WIDTH  Gray code from the upstream counter (may be asynchronous to Clk)
Clear  in  1  synchronous; zeroes counters and leaves FAULT
Bin  out  WIDTH  registered binary of the synchronised Gray value
Step  out  1  one-cycle pulse per legal forward step
Wrap  out  1  one-cycle pulse on legal max->0 step
Err  out  1  one-cycle pulse on illegal change
Locked  out  1  high in TRACK state
Fault  out  1  high in FAULT state
WrapCnt  out  CNT_W  number of wraps, saturating
ErrCnt  out  CNT_W  number of errors, saturating

Behaviour:
- Interface: one clock (Clk). Reset is asynchronous and active-high.
- Reset values: all synchroniser stages, prev, Bin, Step, Wrap, Err, Locked, Fault, WrapCnt and ErrCnt are 0. State is INIT.
- Synchroniser: GrayIn passes through SYNC_STAGES flops. gs is the last stage.
- Bin is the registered gray2bin(gs): bit i = XOR of gs[WIDTH-1:i].
- Latency from a stable GrayIn change to Bin is SYNC_STAGES+1 cycles.
- Register prev loads gs every cycle in every state.
- Definitions: bg = gray2bin(gs), bp = gray2bin(prev). Arithmetic is modulo 2^WIDTH.
- State INIT: Locked=0, no checking, no pulses. Moves to TRACK on the next cycle (prev is now valid).
- State TRACK, with Locked=1, on each cycle:
  - gs==prev: no pulse.
  - bg==bp+1 and popcount(gs^prev)==1: Step=1 next cycle.
  - If that legal step also has bp==2^WIDTH-1 (so bg==0): Wrap=1 as well, and WrapCnt increments, holding at all-ones.
  - Any other change (multi-bit, or backward): Err=1 next cycle, ErrCnt increments (saturating), state goes to FAULT.
- State FAULT: Fault=1, Locked=0. No Step/Wrap/Err pulses and no counting. Bin keeps tracking. Stays in FAULT until Clear.
- Clear, in any state: WrapCnt=0, ErrCnt=0, state goes to INIT next cycle.
  - Clear has priority over a same-cycle step or error: no pulse and no count that cycle.
- Pulses (Step, Wrap, Err) are registered and last exactly one cycle.
- Reset asserted mid-operation: every output drops to 0 asynchronously. After release, the block passes through INIT before checking resumes.
- Counters never wrap. All ones is sticky until Clear or Reset.

Test Plan:
1. WIDTH=3, SYNC_STAGES=2: reset, then drive 000,001,011,010,110,111,101,100,000, each held 2 cycles -> Bin shows 0..7,0 with 3-cycle latency; 8 Step pulses; 1 Wrap pulse (on 100->000); WrapCnt=1; Err never high; Locked=1.
2. In TRACK, GrayIn 001->010 (two bits change) -> Err high exactly 1 cycle; ErrCnt=1; Fault=1; Locked=0. Then drive legal steps -> no Step. Pulse Clear -> INIT for one cycle, Locked=1 the cycle after, ErrCnt=0.
3. Backward single-bit change 011->001 (binary 2->1) -> Err pulse and FAULT; WrapCnt unchanged.
4. CNT_W=2, cycle the full sequence 5 times -> WrapCnt reads 1,2,3,3,3 (saturation).
5. Assert Reset between clock edges while in TRACK with WrapCnt=2 -> all outputs 0 before the next edge. After release, Locked=0 for one cycle, then 1.
6. Clear in the same cycle an illegal jump reaches gs -> Err stays 0, ErrCnt=0, Fault=0, state goes to INIT.

Source files
------------

// File: rtl/gray_step_monitor_if.sv
// Bundle of the Gray-code input, the clear request and all monitor status outputs.
// The monitor takes the slave modport; whoever drives GrayIn/Clear takes master.
interface gray_step_monitor_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] GrayIn;
    logic             Clear;
    logic [WIDTH-1:0] Bin;
    logic             Step;
    logic             Wrap;
    logic             Err;
    logic             Locked;
    logic             Fault;
    logic [CNT_W-1:0] WrapCnt;
    logic [CNT_W-1:0] ErrCnt;

    modport master (
        output GrayIn, Clear,
        input  Bin, Step, Wrap, Err, Locked, Fault, WrapCnt, ErrCnt
    );

    modport slave (
        input  GrayIn, Clear,
        output Bin, Step, Wrap, Err, Locked, Fault, WrapCnt, ErrCnt
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Synchronises an upstream Gray counter, converts it to binary and checks that every
// change is a single legal forward step. Counts wraps and errors with saturation.
module gray_step_monitor #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input logic              Clk,
    input logic              Reset,
    gray_step_monitor_if.slave bus
);

    localparam logic [1:0] StInit  = 2'd0;
    localparam logic [1:0] StTrack = 2'd1;
    localparam logic [1:0] StFault = 2'd2;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bg;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] bp_inc;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             legal;

    logic [1:0]       state_q, state_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign gs      = sync_q[SYNC_STAGES-1];
    assign bg      = gray2bin(gs);
    assign bp      = gray2bin(prev_q);
    assign bp_inc  = bp + WIDTH'(1);
    assign diff    = gs ^ prev_q;
    // Exactly one bit differs: non-zero and a power of two.
    assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign legal   = one_bit && (bg == bp_inc);

    // Synchroniser chain, previous-value register and binary output register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            bin_q  <= '0;
        end else begin
            sync_q[0] <= bus.GrayIn;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= gs;
            bin_q  <= bg;
        end
    end

    // Next-state, pulse and counter logic; Clear overrides any same-cycle event.
    always_comb begin
        state_d    = state_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (bus.Clear) begin
            state_d    = StInit;
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            case (state_q)
                StInit: begin
                    // prev becomes valid after one cycle here
                    state_d = StTrack;
                end
                StTrack: begin
                    if (gs != prev_q) begin
                        if (legal) begin
                            step_d = 1'b1;
                            if (bp == '1) begin
                                wrap_d = 1'b1;
                                if (wrap_cnt_q != '1) begin
                                    wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                                end
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = StFault;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

    // State, registered pulses and saturating counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StInit;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.Bin     = bin_q;
    assign bus.Step    = step_q;
    assign bus.Wrap    = wrap_q;
    assign bus.Err     = err_q;
    assign bus.Locked  = (state_q == StTrack);
    assign bus.Fault   = (state_q == StFault);
    assign bus.WrapCnt = wrap_cnt_q;
    assign bus.ErrCnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor: one CNT_W=8 instance and one CNT_W=2 instance
// share the same GrayIn/Clear stimulus; the narrow one exposes counter saturation.
module tb_gray_step_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] gray;
    logic       clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100, 3'b000};

    gray_step_monitor_if #(.WIDTH(3), .CNT_W(8)) bus8 ();
    gray_step_monitor_if #(.WIDTH(3), .CNT_W(2)) bus2 ();

    assign bus8.GrayIn = gray;
    assign bus8.Clear  = clr;
    assign bus2.GrayIn = gray;
    assign bus2.Clear  = clr;

    gray_step_monitor #(.WIDTH(3), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus8)
    );

    gray_step_monitor #(.WIDTH(3), .SYNC_STAGES(2), .CNT_W(2)) dut_sat (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {bus8.Bin, bus8.Step, bus8.Wrap, bus8.Err, bus8.Locked, bus8.Fault,
                bus8.WrapCnt, bus8.ErrCnt};
    endfunction

    // Drive a new Gray value and wait until its effect is visible on the outputs.
    task automatic go(input logic [2:0] g);
        gray = g;
        repeat (3) tick();
    endtask

    // One full lap 001..000 from 000, each held two cycles, plus flush cycles.
    task automatic run_pass(output int steps, output int wraps, output int errs);
        steps = 0;
        wraps = 0;
        errs  = 0;
        for (int j = 1; j < 9; j++) begin
            gray = seq[j];
            repeat (2) begin
                tick();
                steps += int'(bus8.Step);
                wraps += int'(bus8.Wrap & bus8.Step);
                errs  += int'(bus8.Err);
            end
            // two cycles after a change Bin still shows the previous value
            check("bin_latency", 32'(bus8.Bin), 32'(j - 1));
        end
        repeat (3) begin
            tick();
            steps += int'(bus8.Step);
            wraps += int'(bus8.Wrap & bus8.Step);
            errs  += int'(bus8.Err);
        end
    endtask

    initial begin
        int steps;
        int wraps;
        int errs;
        int cnt;

        rst  = 1'b1;
        gray = 3'b000;
        clr  = 1'b0;
        #4;
        check("reset_outs", all_outs(), 32'd0);
        tick();
        rst = 1'b0;
        check("init_unlocked", 32'(bus8.Locked), 32'd0);
        tick();
        check("track_locked", 32'(bus8.Locked), 32'd1);

        // 1: full legal lap
        run_pass(steps, wraps, errs);
        check("lap_steps", 32'(steps), 32'd8);
        check("lap_wraps", 32'(wraps), 32'd1);
        check("lap_errs", 32'(errs), 32'd0);
        check("lap_wrapcnt", 32'(bus8.WrapCnt), 32'd1);
        check("lap_locked", 32'(bus8.Locked), 32'd1);
        check("lap_bin", 32'(bus8.Bin), 32'd0);
        check("sat_wrapcnt_1", 32'(bus2.WrapCnt), 32'd1);

        // 4: saturation on the narrow counter
        for (int p = 2; p <= 5; p++) begin
            run_pass(steps, wraps, errs);
            check("sat_wrapcnt", 32'(bus2.WrapCnt), 32'((p > 3) ? 3 : p));
        end
        check("wide_wrapcnt", 32'(bus8.WrapCnt), 32'd5);

        // 2: two-bit jump 001->010
        go(3'b001);
        check("pre_step", 32'(bus8.Step), 32'd1);
        check("pre_bin", 32'(bus8.Bin), 32'd1);
        go(3'b010);
        check("jump_err", 32'(bus8.Err), 32'd1);
        check("jump_step", 32'(bus8.Step), 32'd0);
        check("jump_errcnt", 32'(bus8.ErrCnt), 32'd1);
        check("jump_fault", 32'(bus8.Fault), 32'd1);
        check("jump_locked", 32'(bus8.Locked), 32'd0);
        tick();
        check("err_one_cycle", 32'(bus8.Err), 32'd0);
        check("fault_sticky", 32'(bus8.Fault), 32'd1);
        gray = 3'b110;
        cnt = 0;
        repeat (4) begin
            tick();
            cnt += int'(bus8.Step) + int'(bus8.Err);
        end
        check("fault_no_pulse", 32'(cnt), 32'd0);
        check("fault_bin_tracks", 32'(bus8.Bin), 32'd4);
        check("fault_errcnt_hold", 32'(bus8.ErrCnt), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_init_locked", 32'(bus8.Locked), 32'd0);
        check("clear_fault", 32'(bus8.Fault), 32'd0);
        check("clear_errcnt", 32'(bus8.ErrCnt), 32'd0);
        check("clear_wrapcnt", 32'(bus8.WrapCnt), 32'd0);
        tick();
        check("clear_relock", 32'(bus8.Locked), 32'd1);

        // 3: walk forward through a wrap, then step backward 011->001
        go(3'b111);
        go(3'b101);
        go(3'b100);
        go(3'b000);
        check("walk_wrap", 32'(bus8.Wrap), 32'd1);
        go(3'b001);
        go(3'b011);
        check("walk_bin", 32'(bus8.Bin), 32'd2);
        check("walk_wrapcnt", 32'(bus8.WrapCnt), 32'd1);
        go(3'b001);
        check("back_err", 32'(bus8.Err), 32'd1);
        check("back_step", 32'(bus8.Step), 32'd0);
        check("back_fault", 32'(bus8.Fault), 32'd1);
        check("back_wrapcnt", 32'(bus8.WrapCnt), 32'd1);
        check("back_errcnt", 32'(bus8.ErrCnt), 32'd1);

        // 6: Clear in the cycle an illegal jump 001->111 reaches gs
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("t6_locked", 32'(bus8.Locked), 32'd1);
        gray = 3'b111;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_err", 32'(bus8.Err), 32'd0);
        check("t6_errcnt", 32'(bus8.ErrCnt), 32'd0);
        check("t6_fault", 32'(bus8.Fault), 32'd0);
        check("t6_init", 32'(bus8.Locked), 32'd0);
        tick();
        check("t6_relock", 32'(bus8.Locked), 32'd1);
        check("t6_no_err", 32'(bus8.Err), 32'd0);
        check("t6_bin", 32'(bus8.Bin), 32'd5);

        // 5: asynchronous reset mid-operation with WrapCnt=2
        go(3'b101);
        go(3'b100);
        go(3'b000);
        go(3'b001);
        go(3'b011);
        go(3'b010);
        go(3'b110);
        go(3'b111);
        go(3'b101);
        go(3'b100);
        go(3'b000);
        check("t5_wrapcnt", 32'(bus8.WrapCnt), 32'd2);
        check("t5_locked", 32'(bus8.Locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_zero", all_outs(), 32'd0);
        tick();
        check("t5_held_zero", all_outs(), 32'd0);
        rst = 1'b0;
        check("t5_init", 32'(bus8.Locked), 32'd0);
        tick();
        check("t5_relock", 32'(bus8.Locked), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
